// File: rtl/lut_rr_scheduler.sv
// Shared 2-input registered LUT, time-multiplexed across NUM_REQ requesters by a
// round-robin arbiter; each requester owns a 4-bit truth table.
module lut_rr_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter logic [3:0]  DEFAULT_TT = 4'b0001,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we_i,
  input  logic [ID_W-1:0]    cfg_id_i,
  input  logic [3:0]         cfg_tt_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] req_a_i,
  input  logic [NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic               res_valid_o,
  output logic [ID_W-1:0]    res_id_o,
  output logic               res_y_o,
  input  logic               res_ready_i,
  output logic [CNT_W-1:0]   res_count_o
);

  logic [3:0]       tt_q [NUM_REQ];
  logic [3:0]       tt_d [NUM_REQ];
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic             res_y_q, res_y_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic             slot_free;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic [1:0]       lut_idx;
  logic             lut_y;
  logic             accept;

  assign slot_free = !res_valid_q || res_ready_i;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept = slot_free && grant_vld;

  // Table literals read left to right: the MSB is the entry for {a,b}=2'b00.
  assign lut_idx = ~{req_a_i[grant_id], req_b_i[grant_id]};
  assign lut_y   = tt_q[grant_id][lut_idx];

  assign req_ready_o = (accept && !rst) ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    tt_d        = tt_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_y_d     = res_y_q;
    res_count_d = res_count_q;
    if (res_valid_q && res_ready_i && (res_count_q != '1)) begin
      res_count_d = res_count_q + CNT_W'(1);
    end
    if (slot_free) begin
      res_valid_d = accept;
      if (accept) begin
        res_id_d = grant_id;
        res_y_d  = lut_y;
        rr_ptr_d = grant_id;
      end
    end
    // Lookup above uses tt_q, so a same-cycle write only affects later requests.
    if (cfg_we_i && (32'(cfg_id_i) < NUM_REQ)) begin
      tt_d[cfg_id_i] = cfg_tt_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        tt_q[i] <= DEFAULT_TT;
      end
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= 1'b0;
      res_count_q <= '0;
    end else begin
      tt_q        <= tt_d;
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_y_q     <= res_y_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_y_o     = res_y_q;
  assign res_count_o = res_count_q;

endmodule

// File: tb/tb_lut_rr_scheduler.sv
// Randomized bench for lut_rr_scheduler against a cycle-level behavioural model;
// a narrow result counter lets saturation be reached.
module tb_lut_rr_scheduler;

  localparam int unsigned N     = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [IDW-1:0] cfg_id = '0;
  logic [3:0]     cfg_tt = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_a = '0;
  logic [N-1:0]   req_b = '0;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic           res_y;
  logic           res_ready = 1'b0;
  logic [CW-1:0]  res_count;

  int n_checks = 0;
  int n_fail   = 0;

  lut_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW), .DEFAULT_TT(4'b0001), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_id_i(cfg_id), .cfg_tt_i(cfg_tt),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_y_o(res_y),
    .res_ready_i(res_ready), .res_count_o(res_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: tables, last-grant pointer, output slot, counter.
  logic [3:0] m_tt [N];
  int         m_ptr;
  bit         m_valid;
  int         m_id;
  bit         m_y;
  int         m_cnt;

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) m_tt[i] = 4'b0001;
    m_ptr = N - 1; m_valid = 0; m_id = 0; m_y = 0; m_cnt = 0;
  endtask

  function automatic int model_grant();
    if (m_valid && !res_ready) return -1;
    for (int k = 1; k <= int'(N); k++) begin
      int idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r = '0;
    int g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g = model_grant();
    if (m_valid && res_ready && m_cnt != CMAX) m_cnt++;
    if (!m_valid || res_ready) begin
      if (g >= 0) begin
        int ix = 3 - (2 * int'(req_a[g]) + int'(req_b[g]));
        m_valid = 1; m_id = g; m_y = m_tt[g][ix]; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    if (cfg_we) m_tt[cfg_id] = cfg_tt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    n_checks++; if (res_id !== 2'd0 || res_y !== 1'b0) begin n_fail++; $display("FAIL reset_id_y got=%0d/%b exp=0/0", res_id, res_y); end
    n_checks++; if (res_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", res_count); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    model_reset();
  endtask

  task automatic test_basic();
    req_valid = 4'b0001; req_a = 4'b0001; req_b = 4'b0001; res_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_y !== 1'b1)
      begin n_fail++; $display("FAIL basic_result got v=%b id=%0d y=%b exp v=1 id=0 y=1", res_valid, res_id, res_y); end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    req_valid = 4'b0001; req_a = 4'b0001; req_b = 4'b0001; res_ready = 1'b1;
    tick();
    res_ready = 1'b0; req_valid = 4'b1111;
    exp_cnt = m_cnt;
    for (int j = 0; j < 3; j++) begin
      req_a = 4'($urandom); req_b = 4'($urandom);
      @(negedge clk);
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready got=%b exp=0000", req_ready); end
      n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_y !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold got v=%b id=%0d y=%b exp v=1 id=0 y=1", res_valid, res_id, res_y); end
      n_checks++; if (int'(res_count) != exp_cnt) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", res_count, exp_cnt); end
      tick();
    end
    res_ready = 1'b1; req_valid = '0;
    tick();
    @(negedge clk);
    exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
    n_checks++; if (int'(res_count) != exp_cnt) begin n_fail++; $display("FAIL drain_count got=%0d exp=%0d", res_count, exp_cnt); end
    tick();
  endtask

  task automatic test_cfg_xor();
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_tt = 4'b0110; req_valid = '0;
    tick();
    cfg_we = 1'b0; req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0000;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL xor_ready got=%b exp=0100", req_ready); end
    tick();
    req_b = 4'b0100;
    @(negedge clk);
    n_checks++; if (res_id !== 2'd2 || res_y !== 1'b1) begin n_fail++; $display("FAIL xor_10 got id=%0d y=%b exp id=2 y=1", res_id, res_y); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (res_id !== 2'd2 || res_y !== 1'b0) begin n_fail++; $display("FAIL xor_11 got id=%0d y=%b exp id=2 y=0", res_id, res_y); end
    tick();
  endtask

  task automatic test_cfg_same_cycle();
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_tt = 4'b1110;
    req_valid = 4'b0010; req_a = '0; req_b = '0; res_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL samecfg_ready got=%b exp=0010", req_ready); end
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    n_checks++; if (res_y !== 1'b0) begin n_fail++; $display("FAIL samecfg_old got=%b exp=0", res_y); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (res_y !== 1'b1) begin n_fail++; $display("FAIL samecfg_new got=%b exp=1", res_y); end
    tick();
  endtask

  task automatic test_rr_all();
    int start;
    start = (m_ptr + 1) % N;
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      logic [N-1:0] exp_rdy = '0;
      exp_rdy[(start + j) % N] = 1'b1;
      req_a = 4'($urandom); req_b = 4'($urandom);
      @(negedge clk);
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant step=%0d got=%b exp=%b", j, req_ready, exp_rdy); end
      if (j > 0) begin
        n_checks++; if (res_valid !== 1'b1 || int'(res_id) != (start + j - 1) % N)
          begin n_fail++; $display("FAIL rr_id step=%0d got v=%b id=%0d exp id=%0d", j, res_valid, res_id, (start + j - 1) % N); end
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      logic [N-1:0] exp_rdy;
      req_valid = 4'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      cfg_we = ($urandom_range(0, 7) == 0); cfg_id = 2'($urandom); cfg_tt = 4'($urandom);
      exp_rdy = model_ready();
      @(negedge clk);
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", j, req_ready, exp_rdy); end
      n_checks++; if (res_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", j, res_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (int'(res_id) != m_id || res_y !== m_y)
          begin n_fail++; $display("FAIL rand_result cyc=%0d got id=%0d y=%b exp id=%0d y=%b", j, res_id, res_y, m_id, m_y); end
      end
      n_checks++; if (int'(res_count) != m_cnt) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", j, res_count, m_cnt); end
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111; res_ready = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", res_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", res_valid); end
    n_checks++; if (res_count !== 4'd0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", res_count); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    res_ready = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0000;
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (res_id !== 2'd2 || res_y !== 1'b0) begin n_fail++; $display("FAIL mid_default_tt got id=%0d y=%b exp id=2 y=0", res_id, res_y); end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_xor();
    test_cfg_same_cycle();
    test_rr_all();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
